// File: rtl/ws2812_pkg.sv
// WS2812B line constants shared between the LED-ring driver and the loopback receiver.
// All timing values are in clock cycles at the 10 MHz system clock.
package ws2812_pkg;

    localparam int unsigned T0H        = 4;
    localparam int unsigned T1H        = 8;
    localparam int unsigned TBIT       = 12;
    localparam int unsigned TRESET     = 500;

    localparam int unsigned MIN_HIGH_DEFAULT   = 2;
    localparam int unsigned BIT_THRESH_DEFAULT = 6;
    localparam int unsigned MAX_HIGH_DEFAULT   = 12;

    localparam int unsigned PIXEL_BITS = 24;
    localparam int unsigned G_OFFSET   = 16;
    localparam int unsigned R_OFFSET   = 8;
    localparam int unsigned B_OFFSET   = 0;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [1:0] {
        StSyncWait,
        StIdle,
        StHigh,
        StLow
    } rx_state_e;

    function automatic pixel_t pack_grb(input logic [7:0] g, input logic [7:0] r,
                                        input logic [7:0] b);
        pixel_t p;
        p = '0;
        p[G_OFFSET +: 8] = g;
        p[R_OFFSET +: 8] = r;
        p[B_OFFSET +: 8] = b;
        return p;
    endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Synchronizes the WS2812 line and measures high/low run lengths, emitting one-cycle
// event strobes (bit, glitch, stuck-high, latch) for the receiver FSM.
module ws2812_pulse_meter
    import ws2812_pkg::*;
#(
    parameter int unsigned MIN_HIGH     = MIN_HIGH_DEFAULT,
    parameter int unsigned BIT_THRESH   = BIT_THRESH_DEFAULT,
    parameter int unsigned MAX_HIGH     = MAX_HIGH_DEFAULT,
    parameter int unsigned RESET_CYCLES = TRESET
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic rise,
    output logic bit_strobe,
    output logic bit_value,
    output logic glitch,
    output logic stuck,
    output logic latch
);

    localparam int unsigned HI_W  = $clog2(MAX_HIGH + 2);
    localparam int unsigned LOW_W = $clog2(RESET_CYCLES + 1);

    localparam logic [HI_W-1:0]  HI_MIN  = HI_W'(MIN_HIGH);
    localparam logic [HI_W-1:0]  HI_THR  = HI_W'(BIT_THRESH);
    localparam logic [HI_W-1:0]  HI_MAX  = HI_W'(MAX_HIGH);
    localparam logic [HI_W-1:0]  HI_SAT  = HI_W'(MAX_HIGH + 1);
    localparam logic [LOW_W-1:0] LOW_SAT = LOW_W'(RESET_CYCLES);
    localparam logic [LOW_W-1:0] LOW_PRE = LOW_W'(RESET_CYCLES - 1);

    logic             din_meta;
    logic             din_s;
    logic             din_prev;
    logic             fall;
    logic [HI_W-1:0]  hi_cnt;
    logic [HI_W-1:0]  hi_cnt_next;
    logic [LOW_W-1:0] low_cnt;
    logic [LOW_W-1:0] low_cnt_next;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_prev <= 1'b0;
            hi_cnt   <= '0;
            low_cnt  <= '0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            din_prev <= din_s;
            hi_cnt   <= hi_cnt_next;
            low_cnt  <= low_cnt_next;
        end
    end

    always_comb begin
        rise = din_s & ~din_prev;
        fall = ~din_s & din_prev;

        hi_cnt_next = hi_cnt;
        if (rise) begin
            hi_cnt_next = HI_W'(1);
        end else if (din_s && hi_cnt != HI_SAT) begin
            hi_cnt_next = hi_cnt + HI_W'(1);
        end

        // The falling-edge cycle is the first low cycle of the gap.
        low_cnt_next = low_cnt;
        if (din_s) begin
            low_cnt_next = '0;
        end else if (fall) begin
            low_cnt_next = LOW_W'(1);
        end else if (low_cnt != LOW_SAT) begin
            low_cnt_next = low_cnt + LOW_W'(1);
        end
    end

    always_comb begin
        bit_value  = (hi_cnt >= HI_THR);
        bit_strobe = fall && (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);
        glitch     = fall && (hi_cnt < HI_MIN);
        // Fires once, on the high cycle that pushes the width past MAX_HIGH.
        stuck      = din_s && !rise && (hi_cnt == HI_MAX);
        // Fires once per low run; the saturated counter cannot re-arm it.
        latch      = !din_s && (low_cnt == LOW_PRE);
    end

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812B stream decoder: turns measured pulses into 24-bit GRB pixels with frame indexing,
// frame-latch detection and error reporting.
module ws2812_receiver
    import ws2812_pkg::*;
#(
    parameter int unsigned MIN_HIGH     = MIN_HIGH_DEFAULT,
    parameter int unsigned BIT_THRESH   = BIT_THRESH_DEFAULT,
    parameter int unsigned MAX_HIGH     = MAX_HIGH_DEFAULT,
    parameter int unsigned RESET_CYCLES = TRESET
) (
    input  logic        clk,
    input  logic        res,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic [8:0]  pixel_count,
    output logic        bit_error
);

    localparam logic [4:0] LAST_BIT = 5'(PIXEL_BITS - 1);
    localparam logic [8:0] PIX_SAT  = 9'd256;

    logic rise;
    logic bit_strobe;
    logic bit_value;
    logic glitch;
    logic stuck;
    logic latch;

    rx_state_e             state;
    logic [PIXEL_BITS-2:0] shift;
    logic [4:0]            bit_cnt;
    logic [8:0]            pix_cnt;
    pixel_t                pixel_word;

    ws2812_pulse_meter #(
        .MIN_HIGH     (MIN_HIGH),
        .BIT_THRESH   (BIT_THRESH),
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_pulse_meter (
        .clk        (clk),
        .res        (res),
        .din        (din),
        .rise       (rise),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value),
        .glitch     (glitch),
        .stuck      (stuck),
        .latch      (latch)
    );

    assign pixel_word = {shift, bit_value};

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= StSyncWait;
            shift       <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            bit_error   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;

            unique case (state)
                // Only a full latch period realigns us to a frame boundary.
                StSyncWait: begin
                    if (latch) begin
                        state <= StIdle;
                    end
                end

                StIdle: begin
                    if (rise) begin
                        state <= StHigh;
                    end
                end

                StHigh: begin
                    if (stuck) begin
                        bit_error <= 1'b1;
                        shift     <= '0;
                        bit_cnt   <= '0;
                        state     <= StSyncWait;
                    end else if (glitch) begin
                        bit_error <= 1'b1;
                        state     <= StLow;
                    end else if (bit_strobe) begin
                        shift <= pixel_word[PIXEL_BITS-2:0];
                        state <= StLow;
                        if (bit_cnt == LAST_BIT) begin
                            pixel_data  <= pixel_word;
                            pixel_valid <= 1'b1;
                            pixel_index <= pix_cnt[8] ? 8'hFF : pix_cnt[7:0];
                            if (pix_cnt != PIX_SAT) begin
                                pix_cnt <= pix_cnt + 9'd1;
                            end
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                StLow: begin
                    if (latch) begin
                        frame_done  <= 1'b1;
                        pixel_count <= pix_cnt;
                        pix_cnt     <= '0;
                        // A latch mid-pixel means the tail of the frame was truncated.
                        if (bit_cnt != '0) begin
                            bit_error <= 1'b1;
                        end
                        bit_cnt <= '0;
                        shift   <= '0;
                        state   <= StIdle;
                    end else if (rise) begin
                        state <= StHigh;
                    end
                end

                default: begin
                    state <= StSyncWait;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_receiver.sv
// Scoreboard bench for ws2812_receiver: drives WS2812 waveforms, queues expected pixels
// and compares them as pixel_valid pulses appear.
`timescale 1ns / 1ps
module tb_ws2812_receiver;
    import ws2812_pkg::*;

    logic        clk = 1'b0;
    logic        res;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic [8:0]  pixel_count;
    logic        bit_error;

    int checks   = 0;
    int failures = 0;
    int frame_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int valid_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #50 clk = ~clk;

    ws2812_receiver dut (
        .clk         (clk),
        .res         (res),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .bit_error   (bit_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!res) begin
            if (pixel_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("pixel_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pixel_data", 32'(pixel_data), 32'(mon_exp[23:0]));
                    check("pixel_index", 32'(pixel_index), 32'(mon_exp[31:24]));
                end
            end
            if (frame_done) frame_cnt++;
            if (bit_error) err_cnt++;
            if (frame_done && bit_error) both_cnt++;
        end
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, T1H);
            hold(1'b0, TBIT - T1H);
        end else begin
            hold(1'b1, T0H);
            hold(1'b0, TBIT - T0H);
        end
    endtask

    task automatic send_pixel(input logic [23:0] p, input int idx);
        exp_q.push_back({8'(idx), p});
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_pixel_data"}, 32'(pixel_data), 32'd0);
        check({phase, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({phase, "_pixel_index"}, 32'(pixel_index), 32'd0);
        check({phase, "_frame_done"}, 32'(frame_done), 32'd0);
        check({phase, "_pixel_count"}, 32'(pixel_count), 32'd0);
        check({phase, "_bit_error"}, 32'(bit_error), 32'd0);
    endtask

    initial begin
        logic [23:0] p;

        res = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        res = 1'b0;
        hold(1'b0, 520);
        check("sync_no_frame", 32'(frame_cnt), 32'd0);

        // 1: single pixel with exact output latency on the final bit
        p = pack_grb(8'hFF, 8'h00, 8'h00);
        exp_q.push_back({8'd0, p});
        for (int i = 23; i >= 1; i--) send_bit(p[i]);
        hold(1'b1, T0H);
        din = 1'b0;
        repeat (2) @(negedge clk);
        check("latency_early", 32'(pixel_valid), 32'd0);
        @(negedge clk);
        check("latency_hit", 32'(pixel_valid), 32'd1);
        hold(1'b0, TBIT - T0H - 3);
        hold(1'b0, 600);
        check("t1_frames", 32'(frame_cnt), 32'd1);
        check("t1_count", 32'(pixel_count), 32'd1);

        // 2: three pixels, one latch
        send_pixel(24'h123456, 0);
        send_pixel(24'hABCDEF, 1);
        send_pixel(24'h000001, 2);
        hold(1'b0, 600);
        check("t2_frames", 32'(frame_cnt), 32'd2);
        check("t2_count", 32'(pixel_count), 32'd3);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_errors", 32'(err_cnt), 32'd0);

        // 3: truncated pixel at latch
        for (int i = 0; i < 10; i++) send_bit(1'(i));
        hold(1'b0, 520);
        check("t3_frames", 32'(frame_cnt), 32'd3);
        check("t3_count", 32'(pixel_count), 32'd0);
        check("t3_errors", 32'(err_cnt), 32'd1);
        check("t3_coincident", 32'(both_cnt), 32'd1);
        check("t3_valids", 32'(valid_cnt), 32'd4);

        // 4: glitch between bits 5 and 6
        p = 24'hA5A5A5;
        exp_q.push_back({8'd0, p});
        for (int i = 23; i >= 18; i--) send_bit(p[i]);
        hold(1'b1, 1);
        hold(1'b0, 4);
        for (int i = 17; i >= 0; i--) send_bit(p[i]);
        hold(1'b0, 520);
        check("t4_errors", 32'(err_cnt), 32'd2);
        check("t4_frames", 32'(frame_cnt), 32'd4);
        check("t4_count", 32'(pixel_count), 32'd1);

        // 5: stuck high mid-pixel, then resync
        for (int i = 0; i < 10; i++) send_bit(1'(i + 1));
        hold(1'b1, 12);
        check("t5_stuck_early", 32'(err_cnt), 32'd2);
        hold(1'b1, 8);
        check("t5_stuck", 32'(err_cnt), 32'd3);
        hold(1'b0, 520);
        check("t5_no_frame", 32'(frame_cnt), 32'd4);
        send_pixel(24'h0F0F0F, 0);
        hold(1'b0, 520);
        check("t5_frames", 32'(frame_cnt), 32'd5);
        check("t5_count", 32'(pixel_count), 32'd1);
        check("t5_errors", 32'(err_cnt), 32'd3);

        // 6: reset during bit 12
        p = 24'h111111;
        for (int i = 23; i >= 13; i--) send_bit(p[i]);
        din = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        din = 1'b0;
        res = 1'b0;
        hold(1'b0, 520);
        send_pixel(24'hC3A55A, 0);
        hold(1'b0, 520);
        check("t6_frames", 32'(frame_cnt), 32'd6);
        check("t6_count", 32'(pixel_count), 32'd1);
        check("t6_errors", 32'(err_cnt), 32'd3);
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("valid_total", 32'(valid_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
